pc_fetch_unit: RTL

Instruction-fetch stage feeding the single-issue MIPS pipeline. Holds the PC and issues word fetches to instruction memory over a req/ack handshake. Loads fetched instructions into the IF/ID register. Consumes the next-PC redirect produced by the branch/jump logic, and handles squashing of in-flight fetches and decode stalls with a one-entry buffer.

---
 rtl/pc_fetch_unit_pkg.sv | 16 +
 rtl/fetch_skid_buf.sv | 31 +++
 rtl/pc_fetch_unit.sv | 121 ++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared pipeline constants for the instruction-fetch stage.
package pc_fetch_unit_pkg;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam logic [ADDR_W-1:0] WORD_MASK        = 32'hFFFF_FFFC;
  localparam logic [ADDR_W-1:0] PC_STEP          = 32'd4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;
  localparam logic [1:0] ST_FULL = 2'd3;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding buffer for an instruction fetched while decode is stalled.
module fetch_skid_buf
  import pc_fetch_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              unload,
  input  logic              clear,
  input  logic [ADDR_W-1:0] load_pc,
  input  logic [INST_W-1:0] load_inst,
  output logic              buf_valid,
  output logic [ADDR_W-1:0] buf_pc,
  output logic [INST_W-1:0] buf_inst
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_valid <= 1'b0;
      buf_pc    <= '0;
      buf_inst  <= '0;
    end else if (clear || unload) begin
      buf_valid <= 1'b0;
    end else if (load) begin
      buf_valid <= 1'b1;
      buf_pc    <= load_pc;
      buf_inst  <= load_inst;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: PC, imem req/ack handshake, IF/ID register, redirect and stall handling.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              npc_valid,
  input  logic [ADDR_W-1:0] npc,
  input  logic              stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0] if_inst
);

  logic [1:0]        state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] target_pc;
  logic [ADDR_W-1:0] npc_aligned;

  logic              buf_load;
  logic              buf_unload;
  logic              buf_valid;
  logic [ADDR_W-1:0] buf_pc;
  logic [INST_W-1:0] buf_inst;

  // Request lines come from registered state only, never from ack/stall/npc_valid.
  assign imem_req    = (state == ST_REQ) || (state == ST_DROP);
  assign imem_addr   = fetch_pc;
  assign npc_aligned = npc & WORD_MASK;

  assign buf_load   = (state == ST_REQ) && imem_ack && stall && !npc_valid;
  assign buf_unload = (state == ST_FULL) && !stall && !npc_valid;

  fetch_skid_buf u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (buf_load),
    .unload    (buf_unload),
    .clear     (npc_valid),
    .load_pc   (fetch_pc),
    .load_inst (imem_rdata),
    .buf_valid (buf_valid),
    .buf_pc    (buf_pc),
    .buf_inst  (buf_inst)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      fetch_pc  <= RESET_PC;
      target_pc <= RESET_PC;
      if_valid  <= 1'b0;
      if_pc     <= '0;
      if_inst   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state <= ST_REQ;
          if (npc_valid) begin
            if_valid <= 1'b0;
            fetch_pc <= npc_aligned;
          end else if (!stall) begin
            if_valid <= 1'b0;
          end
        end
        ST_REQ: begin
          // A redirect without ack must let the old request finish before retargeting.
          if (npc_valid) begin
            if_valid <= 1'b0;
            if (imem_ack) begin
              fetch_pc <= npc_aligned;
            end else begin
              target_pc <= npc_aligned;
              state     <= ST_DROP;
            end
          end else if (imem_ack) begin
            fetch_pc <= fetch_pc + PC_STEP;
            if (stall) begin
              state <= ST_FULL;
            end else begin
              if_valid <= 1'b1;
              if_pc    <= fetch_pc;
              if_inst  <= imem_rdata;
            end
          end else if (!stall) begin
            if_valid <= 1'b0;
          end
        end
        ST_DROP: begin
          if_valid <= 1'b0;
          if (imem_ack) begin
            fetch_pc <= npc_valid ? npc_aligned : target_pc;
            state    <= ST_REQ;
          end else if (npc_valid) begin
            target_pc <= npc_aligned;
          end
        end
        ST_FULL: begin
          if (npc_valid) begin
            if_valid <= 1'b0;
            fetch_pc <= npc_aligned;
            state    <= ST_REQ;
          end else if (!stall) begin
            if_valid <= buf_valid;
            if_pc    <= buf_pc;
            if_inst  <= buf_inst;
            state    <= ST_REQ;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
